// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants: the null tag, default tag width and the tag increment that
// skips the null tag.
package reorder_buffer_pkg;

  localparam int unsigned RobWidthDefault = 4;
  localparam int unsigned RobNull         = 0;

  // Tags run 1..2^width-1; the null tag is never produced.
  function automatic int unsigned tag_inc(input int unsigned tag, input int unsigned width);
    int unsigned max_tag;
    max_tag = (32'd1 << width) - 32'd1;
    return (tag == max_tag) ? 32'd1 : tag + 32'd1;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, result-bus, operand-query and commit signals of the reorder buffer.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = RobWidthDefault
);

  logic                 issue_valid;
  logic [4:0]           issue_rd_id;
  logic                 issue_is_branch;
  logic                 issue_pred_taken;
  logic [31:0]          issue_redirect_pc;
  logic                 rob_full;
  logic [ROB_WIDTH-1:0] rob_next_index;

  logic                 cdb_valid;
  logic [ROB_WIDTH-1:0] cdb_rob_index;
  logic [31:0]          cdb_val;
  logic                 cdb_taken;

  logic [ROB_WIDTH-1:0] query1_index;
  logic [ROB_WIDTH-1:0] query2_index;
  logic                 query1_ready;
  logic                 query2_ready;
  logic [31:0]          query1_val;
  logic [31:0]          query2_val;

  logic                 rob_to_rf_ready;
  logic [4:0]           rob_to_rf_reg_id;
  logic [31:0]          rob_to_rf_reg_val;
  logic [ROB_WIDTH-1:0] rob_to_rf_rob_index;
  logic                 clr_out;
  logic [31:0]          clr_pc;

  modport master (
    output issue_valid, issue_rd_id, issue_is_branch, issue_pred_taken, issue_redirect_pc,
    output cdb_valid, cdb_rob_index, cdb_val, cdb_taken, query1_index, query2_index,
    input  rob_full, rob_next_index, query1_ready, query2_ready, query1_val, query2_val,
    input  rob_to_rf_ready, rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_index,
    input  clr_out, clr_pc
  );

  modport slave (
    input  issue_valid, issue_rd_id, issue_is_branch, issue_pred_taken, issue_redirect_pc,
    input  cdb_valid, cdb_rob_index, cdb_val, cdb_taken, query1_index, query2_index,
    output rob_full, rob_next_index, query1_ready, query2_ready, query1_val, query2_val,
    output rob_to_rf_ready, rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_index,
    output clr_out, clr_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order commit stage: allocates tags, captures CDB results, retires the head entry into the
// register file and flushes speculative state on a mispredicted branch at commit.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = RobWidthDefault
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  reorder_buffer_if.slave rob
);

  localparam int unsigned Depth = 2 ** ROB_WIDTH;
  typedef logic [ROB_WIDTH-1:0] tag_t;
  localparam tag_t FirstTag = tag_t'(1);
  localparam tag_t MaxTag   = tag_t'(Depth - 1);
  localparam tag_t NullTag  = tag_t'(RobNull);

  logic        busy_q        [Depth];
  logic        ready_q       [Depth];
  logic [4:0]  rd_q          [Depth];
  logic [31:0] val_q         [Depth];
  logic        is_branch_q   [Depth];
  logic        pred_taken_q  [Depth];
  logic        taken_q       [Depth];
  logic [31:0] redirect_pc_q [Depth];

  tag_t        head_q, tail_q, count_q;
  logic        rf_ready_q;
  logic [4:0]  rf_reg_id_q;
  logic [31:0] rf_reg_val_q;
  tag_t        rf_rob_index_q;
  logic        clr_q;
  logic [31:0] clr_pc_q;

  logic        full, do_alloc, cdb_hit, do_commit, mispredict;
  tag_t        head_inc, tail_inc;
  tag_t        q_idx [2];
  logic [32:0] q_res [2];

  always_comb begin
    full       = (count_q == MaxTag);
    do_alloc   = rob.issue_valid && !full && !clr_q;
    cdb_hit    = rob.cdb_valid && !clr_q && busy_q[rob.cdb_rob_index];
    do_commit  = busy_q[head_q] && ready_q[head_q];
    mispredict = do_commit && is_branch_q[head_q] && (taken_q[head_q] != pred_taken_q[head_q]);
    head_inc   = tag_t'(tag_inc(32'(head_q), ROB_WIDTH));
    tail_inc   = tag_t'(tag_inc(32'(tail_q), ROB_WIDTH));
  end

  // Operand lookup: a same-cycle CDB broadcast wins over the stored value.
  always_comb begin
    q_idx[0] = rob.query1_index;
    q_idx[1] = rob.query2_index;
    for (int i = 0; i < 2; i++) begin
      q_res[i] = '0;
      if (q_idx[i] == NullTag) begin
        q_res[i] = '0;
      end else if (rob.cdb_valid && !clr_q && rob.cdb_rob_index == q_idx[i]) begin
        q_res[i] = {1'b1, rob.cdb_val};
      end else if (busy_q[q_idx[i]] && ready_q[q_idx[i]]) begin
        q_res[i] = {1'b1, val_q[q_idx[i]]};
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q         <= FirstTag;
      tail_q         <= FirstTag;
      count_q        <= '0;
      rf_ready_q     <= 1'b0;
      rf_reg_id_q    <= '0;
      rf_reg_val_q   <= '0;
      rf_rob_index_q <= '0;
      clr_q          <= 1'b0;
      clr_pc_q       <= '0;
      for (int i = 0; i < Depth; i++) busy_q[i] <= 1'b0;
    end else if (rdy_in) begin
      rf_ready_q <= 1'b0;
      clr_q      <= 1'b0;
      if (do_alloc) begin
        busy_q[tail_q]        <= 1'b1;
        ready_q[tail_q]       <= 1'b0;
        rd_q[tail_q]          <= rob.issue_rd_id;
        is_branch_q[tail_q]   <= rob.issue_is_branch;
        pred_taken_q[tail_q]  <= rob.issue_pred_taken;
        redirect_pc_q[tail_q] <= rob.issue_redirect_pc;
        tail_q                <= tail_inc;
      end
      if (cdb_hit) begin
        ready_q[rob.cdb_rob_index] <= 1'b1;
        val_q[rob.cdb_rob_index]   <= rob.cdb_val;
        taken_q[rob.cdb_rob_index] <= rob.cdb_taken;
      end
      if (do_commit) begin
        rf_ready_q     <= 1'b1;
        rf_reg_id_q    <= rd_q[head_q];
        rf_reg_val_q   <= val_q[head_q];
        rf_rob_index_q <= head_q;
        busy_q[head_q] <= 1'b0;
        head_q         <= head_inc;
      end
      case ({do_alloc, do_commit})
        2'b10:   count_q <= count_q + tag_t'(1);
        2'b01:   count_q <= count_q - tag_t'(1);
        default: count_q <= count_q;
      endcase
      // A flush overrides the allocation, CDB capture and pointer moves above.
      if (mispredict) begin
        clr_q    <= 1'b1;
        clr_pc_q <= redirect_pc_q[head_q];
        head_q   <= FirstTag;
        tail_q   <= FirstTag;
        count_q  <= '0;
        for (int i = 0; i < Depth; i++) busy_q[i] <= 1'b0;
      end
    end
  end

  assign rob.rob_full            = full;
  assign rob.rob_next_index      = tail_q;
  assign rob.query1_ready        = q_res[0][32];
  assign rob.query1_val          = q_res[0][31:0];
  assign rob.query2_ready        = q_res[1][32];
  assign rob.query2_val          = q_res[1][31:0];
  assign rob.rob_to_rf_ready     = rf_ready_q;
  assign rob.rob_to_rf_reg_id    = rf_reg_id_q;
  assign rob.rob_to_rf_reg_val   = rf_reg_val_q;
  assign rob.rob_to_rf_rob_index = rf_rob_index_q;
  assign rob.clr_out             = clr_q;
  assign rob.clr_pc              = clr_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus a randomized run checked against a
// queue-of-instructions model of in-order commit with flush on mispredict.
module tb_reorder_buffer;

  localparam int unsigned W = 4;
  localparam int MaxTag = 15;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  always #5 clk_in = ~clk_in;

  reorder_buffer_if #(.ROB_WIDTH(W)) bus ();
  reorder_buffer #(.ROB_WIDTH(W)) dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob(bus));

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    bit          br;
    bit          pred;
    logic [31:0] pc;
    bit          done;
    logic [31:0] val;
    bit          taken;
  } ent_t;

  ent_t        mq[$];
  int          m_next = 1;
  bit          m_clr = 1'b0;
  bit          m_cv = 1'b0;
  logic [31:0] m_clr_pc = '0;
  logic [31:0] m_cval = '0;
  logic [4:0]  m_crd = '0;
  int          m_ctag = 0;
  int          vectors = 0;
  int          errors = 0;

  // Reference model: one call per clock edge, using the inputs present before that edge.
  function automatic void model_step();
    bit   was_clr, full, com, mis;
    ent_t e;
    if (rst_in) begin
      mq.delete();
      m_next = 1; m_clr = 0; m_cv = 0; m_clr_pc = '0;
      return;
    end
    if (!rdy_in) return;
    was_clr = m_clr;
    full    = (mq.size() == MaxTag);
    com     = 0;
    mis     = 0;
    m_cv    = 0;
    m_clr   = 0;
    if (mq.size() > 0 && mq[0].done) begin
      com = 1; m_cv = 1;
      m_crd = mq[0].rd; m_cval = mq[0].val; m_ctag = mq[0].tag;
      mis = mq[0].br && (mq[0].taken != mq[0].pred);
      if (mis) m_clr_pc = mq[0].pc;
    end
    if (!was_clr && bus.cdb_valid) begin
      foreach (mq[i]) begin
        if (mq[i].tag == int'(bus.cdb_rob_index)) begin
          mq[i].done = 1; mq[i].val = bus.cdb_val; mq[i].taken = bus.cdb_taken;
        end
      end
    end
    if (com) void'(mq.pop_front());
    if (mis) begin
      mq.delete();
      m_next = 1;
      m_clr  = 1;
    end else if (bus.issue_valid && !full && !was_clr) begin
      e.tag = m_next; e.rd = bus.issue_rd_id; e.br = bus.issue_is_branch;
      e.pred = bus.issue_pred_taken; e.pc = bus.issue_redirect_pc;
      e.done = 0; e.val = '0; e.taken = 0;
      mq.push_back(e);
      m_next = (m_next == MaxTag) ? 1 : m_next + 1;
    end
  endfunction

  function automatic logic [32:0] model_query(input logic [3:0] idx);
    if (idx == 4'd0) return '0;
    if (!m_clr && bus.cdb_valid && bus.cdb_rob_index == idx) return {1'b1, bus.cdb_val};
    foreach (mq[i]) if (mq[i].tag == int'(idx) && mq[i].done) return {1'b1, mq[i].val};
    return '0;
  endfunction

  task automatic drive_idle();
    bus.issue_valid = 0; bus.issue_rd_id = '0; bus.issue_is_branch = 0;
    bus.issue_pred_taken = 0; bus.issue_redirect_pc = '0;
    bus.cdb_valid = 0; bus.cdb_rob_index = '0; bus.cdb_val = '0; bus.cdb_taken = 0;
    bus.query1_index = '0; bus.query2_index = '0;
  endtask

  task automatic drive_issue(input logic [4:0] rd, input bit br, input bit pred,
                             input logic [31:0] pc);
    bus.issue_valid = 1; bus.issue_rd_id = rd; bus.issue_is_branch = br;
    bus.issue_pred_taken = pred; bus.issue_redirect_pc = pc;
  endtask

  task automatic drive_cdb(input int tag, input logic [31:0] val, input bit taken);
    bus.cdb_valid = 1; bus.cdb_rob_index = 4'(tag); bus.cdb_val = val; bus.cdb_taken = taken;
  endtask

  task automatic tick();
    @(negedge clk_in);
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1; rdy_in = 1;
    drive_idle();
    tick(); tick();
    rst_in = 0;
  endtask

  task automatic test_reset();
    do_reset();
    drive_issue(5'd3, 0, 0, '0); tick(); tick();
    drive_idle();
    do_reset();
    vectors++; if (bus.rob_next_index !== 4'd1) begin errors++; $display("FAIL reset_next_index: got %0d want 1", bus.rob_next_index); end
    vectors++; if (bus.rob_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.rob_full); end
    vectors++; if (bus.rob_to_rf_ready !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b want 0", bus.rob_to_rf_ready); end
    vectors++; if ({bus.rob_to_rf_reg_id, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index} !== '0) begin errors++; $display("FAIL reset_commit_fields: got %h/%h/%h want 0", bus.rob_to_rf_reg_id, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index); end
    vectors++; if (bus.clr_out !== 1'b0 || bus.clr_pc !== 32'h0) begin errors++; $display("FAIL reset_clr: got %b/%h want 0/0", bus.clr_out, bus.clr_pc); end
    vectors++; if (bus.query1_ready !== 1'b0 || bus.query1_val !== 32'h0) begin errors++; $display("FAIL reset_query: got %b/%h want 0/0", bus.query1_ready, bus.query1_val); end
  endtask

  task automatic test_in_order_commit();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_issue(5'd5, 0, 0, '0);
      tick();
      vectors++; if (bus.rob_next_index !== 4'(i + 2)) begin errors++; $display("FAIL issue_tag: got %0d want %0d", bus.rob_next_index, i + 2); end
    end
    drive_idle(); drive_cdb(2, 32'h22, 0); tick();
    vectors++; if (bus.rob_to_rf_ready !== 1'b0) begin errors++; $display("FAIL ooo_no_commit: got %b want 0", bus.rob_to_rf_ready); end
    drive_cdb(1, 32'h11, 0); tick();
    vectors++; if (bus.rob_to_rf_ready !== 1'b0) begin errors++; $display("FAIL cdb_latency: got %b want 0", bus.rob_to_rf_ready); end
    drive_idle(); tick();
    vectors++; if ({bus.rob_to_rf_ready, bus.rob_to_rf_reg_id, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index} !== {1'b1, 5'd5, 32'h11, 4'd1}) begin errors++; $display("FAIL commit_first: got %b/%0d/%h/%0d want 1/5/11/1", bus.rob_to_rf_ready, bus.rob_to_rf_reg_id, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index); end
    tick();
    vectors++; if ({bus.rob_to_rf_ready, bus.rob_to_rf_reg_id, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index} !== {1'b1, 5'd5, 32'h22, 4'd2}) begin errors++; $display("FAIL commit_second: got %b/%0d/%h/%0d want 1/5/22/2", bus.rob_to_rf_ready, bus.rob_to_rf_reg_id, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index); end
    tick();
    vectors++; if (bus.rob_to_rf_ready !== 1'b0) begin errors++; $display("FAIL commit_stop: got %b want 0", bus.rob_to_rf_ready); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive_issue(5'(i + 1), 0, 0, '0);
      tick();
    end
    vectors++; if (bus.rob_full !== 1'b1 || bus.rob_next_index !== 4'd1) begin errors++; $display("FAIL full_after_15: got %b/%0d want 1/1", bus.rob_full, bus.rob_next_index); end
    tick();
    vectors++; if (bus.rob_full !== 1'b1 || bus.rob_next_index !== 4'd1) begin errors++; $display("FAIL full_ignores_issue: got %b/%0d want 1/1", bus.rob_full, bus.rob_next_index); end
    drive_cdb(1, 32'h77, 0); tick();
    bus.cdb_valid = 0; tick();
    vectors++; if ({bus.rob_to_rf_ready, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index} !== {1'b1, 32'h77, 4'd1}) begin errors++; $display("FAIL full_commit: got %b/%h/%0d want 1/77/1", bus.rob_to_rf_ready, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index); end
    vectors++; if (bus.rob_full !== 1'b0 || bus.rob_next_index !== 4'd1) begin errors++; $display("FAIL no_same_cycle_alloc: got %b/%0d want 0/1", bus.rob_full, bus.rob_next_index); end
    tick();
    vectors++; if (bus.rob_full !== 1'b1 || bus.rob_next_index !== 4'd2) begin errors++; $display("FAIL wrap_alloc: got %b/%0d want 1/2", bus.rob_full, bus.rob_next_index); end
    drive_idle();
  endtask

  task automatic test_mispredict();
    do_reset();
    drive_issue(5'd1, 0, 0, '0); tick();
    drive_issue(5'd2, 0, 0, '0); tick();
    drive_issue(5'd3, 1, 0, 32'h100); tick();
    drive_issue(5'd4, 0, 0, '0); tick();
    drive_idle();
    drive_cdb(1, 32'h1, 0); tick();
    drive_cdb(2, 32'h2, 0); tick();
    drive_cdb(3, 32'h104, 1); tick();
    drive_idle(); tick();
    vectors++; if (bus.clr_out !== 1'b1 || bus.clr_pc !== 32'h100) begin errors++; $display("FAIL flush_pulse: got %b/%h want 1/100", bus.clr_out, bus.clr_pc); end
    vectors++; if ({bus.rob_to_rf_ready, bus.rob_to_rf_reg_id, bus.rob_to_rf_rob_index} !== {1'b1, 5'd3, 4'd3}) begin errors++; $display("FAIL flush_commit: got %b/%0d/%0d want 1/3/3", bus.rob_to_rf_ready, bus.rob_to_rf_reg_id, bus.rob_to_rf_rob_index); end
    vectors++; if (bus.rob_next_index !== 4'd1 || bus.rob_full !== 1'b0) begin errors++; $display("FAIL flush_ptrs: got %0d/%b want 1/0", bus.rob_next_index, bus.rob_full); end
    drive_issue(5'd6, 0, 0, '0); drive_cdb(4, 32'h44, 0); tick();
    vectors++; if (bus.clr_out !== 1'b0 || bus.rob_next_index !== 4'd1 || bus.rob_to_rf_ready !== 1'b0) begin errors++; $display("FAIL flush_cycle_ignores: got %b/%0d/%b want 0/1/0", bus.clr_out, bus.rob_next_index, bus.rob_to_rf_ready); end
    drive_idle();
  endtask

  task automatic test_query_bypass();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_issue(5'd7, 0, 0, '0); tick();
    end
    drive_idle();
    bus.query1_index = 4'd4; bus.query2_index = 4'd0;
    drive_cdb(4, 32'hAB, 0);
    @(negedge clk_in);
    vectors++; if (bus.query1_ready !== 1'b1 || bus.query1_val !== 32'hAB) begin errors++; $display("FAIL query_bypass: got %b/%h want 1/ab", bus.query1_ready, bus.query1_val); end
    vectors++; if (bus.query2_ready !== 1'b0 || bus.query2_val !== 32'h0) begin errors++; $display("FAIL query_null: got %b/%h want 0/0", bus.query2_ready, bus.query2_val); end
    model_step();
    @(posedge clk_in); #1;
    drive_idle(); bus.query1_index = 4'd4; bus.query2_index = 4'd3;
    #1;
    vectors++; if (bus.query1_ready !== 1'b1 || bus.query1_val !== 32'hAB) begin errors++; $display("FAIL query_stored: got %b/%h want 1/ab", bus.query1_ready, bus.query1_val); end
    vectors++; if (bus.query2_ready !== 1'b0) begin errors++; $display("FAIL query_pending: got %b want 0", bus.query2_ready); end
    drive_idle();
  endtask

  task automatic test_rdy_hold();
    do_reset();
    drive_issue(5'd9, 0, 0, '0); tick(); tick();
    drive_idle(); drive_cdb(1, 32'h55, 0); tick();
    drive_cdb(2, 32'h66, 0); tick();
    drive_idle();
    rdy_in = 0;
    drive_issue(5'd9, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if ({bus.rob_to_rf_ready, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index, bus.rob_next_index} !== {1'b1, 32'h55, 4'd1, 4'd3}) begin errors++; $display("FAIL rdy_frozen: got %b/%h/%0d/%0d want 1/55/1/3", bus.rob_to_rf_ready, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index, bus.rob_next_index); end
    end
    drive_idle(); rdy_in = 1; tick();
    vectors++; if ({bus.rob_to_rf_ready, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index} !== {1'b1, 32'h66, 4'd2}) begin errors++; $display("FAIL rdy_resume: got %b/%h/%0d want 1/66/2", bus.rob_to_rf_ready, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index); end
    tick();
    vectors++; if (bus.rob_to_rf_ready !== 1'b0) begin errors++; $display("FAIL rdy_single: got %b want 0", bus.rob_to_rf_ready); end
  endtask

  task automatic test_random();
    logic [32:0] e1, e2;
    int          pend[$];
    int          ctag;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst_in = ($urandom_range(0, 199) == 0);
      rdy_in = ($urandom_range(0, 7) != 0);
      drive_issue(5'($urandom), $urandom_range(0, 3) == 0, 1'($urandom), $urandom);
      bus.issue_valid = 1'($urandom);
      pend.delete();
      foreach (mq[i]) if (!mq[i].done) pend.push_back(mq[i].tag);
      if (pend.size() > 0 && $urandom_range(0, 9) < 8) ctag = pend[$urandom_range(0, pend.size() - 1)];
      else ctag = $urandom_range(0, 15);
      drive_cdb(ctag, $urandom, 1'($urandom));
      bus.cdb_valid = ($urandom_range(0, 9) < 6);
      bus.query1_index = 4'($urandom_range(0, 15));
      bus.query2_index = ($urandom_range(0, 3) == 0) ? 4'(ctag) : 4'($urandom_range(0, 15));
      @(negedge clk_in);
      e1 = model_query(bus.query1_index);
      e2 = model_query(bus.query2_index);
      vectors++; if (bus.query1_ready !== e1[32] || (e1[32] && bus.query1_val !== e1[31:0])) begin errors++; $display("FAIL rand_query1: got %b/%h want %b/%h", bus.query1_ready, bus.query1_val, e1[32], e1[31:0]); end
      vectors++; if (bus.query2_ready !== e2[32] || (e2[32] && bus.query2_val !== e2[31:0])) begin errors++; $display("FAIL rand_query2: got %b/%h want %b/%h", bus.query2_ready, bus.query2_val, e2[32], e2[31:0]); end
      model_step();
      @(posedge clk_in); #1;
      vectors++; if (bus.rob_next_index !== 4'(m_next) || bus.rob_full !== (mq.size() == MaxTag)) begin errors++; $display("FAIL rand_alloc: got %0d/%b want %0d/%b", bus.rob_next_index, bus.rob_full, m_next, mq.size() == MaxTag); end
      vectors++; if (bus.rob_to_rf_ready !== m_cv || bus.clr_out !== m_clr) begin errors++; $display("FAIL rand_pulses: got %b/%b want %b/%b", bus.rob_to_rf_ready, bus.clr_out, m_cv, m_clr); end
      if (m_cv) begin
        vectors++; if ({bus.rob_to_rf_reg_id, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index} !== {m_crd, m_cval, 4'(m_ctag)}) begin errors++; $display("FAIL rand_commit: got %0d/%h/%0d want %0d/%h/%0d", bus.rob_to_rf_reg_id, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_index, m_crd, m_cval, m_ctag); end
      end
      if (m_clr) begin
        vectors++; if (bus.clr_pc !== m_clr_pc) begin errors++; $display("FAIL rand_clr_pc: got %h want %h", bus.clr_pc, m_clr_pc); end
      end
    end
    rst_in = 0; rdy_in = 1;
    drive_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_in_order_commit();
    test_full_wrap();
    test_mispredict();
    test_query_bypass();
    test_rdy_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order commit stage directly upstream of the register file. Allocates one tag per issued instruction and captures results from the common data bus. Retires the head entry each cycle into the register file's commit port. On a branch mispredict at commit, it flushes the speculative state and redirects fetch. Tag 0 is the register file's "no dependency" value and is never allocated.

## Interface
- ROB_WIDTH, 4, tag width; entries use tags 1..2^ROB_WIDTH-1 (15 at default)
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- rdy_in  in  1  global enable; low freezes all state and outputs
- issue_valid  in  1  allocate an entry this cycle
- issue_rd_id  in  5  destination register (0 = none)
- issue_is_branch  in  1  entry is a conditional branch
- issue_pred_taken  in  1  predicted direction
- issue_redirect_pc  in  32  PC to fetch if the prediction proves wrong
- rob_full  out  1  no free entry; issue_valid is ignored while high
- rob_next_index  out  ROB_WIDTH  tag the next allocation receives (drives RegFile issue_rob_index)
- cdb_valid  in  1  result broadcast
- cdb_rob_index  in  ROB_WIDTH  tag of the result
- cdb_val  in  32  result value
- cdb_taken  in  1  resolved branch direction
- query1_index / query2_index  in  ROB_WIDTH  operand tags from issue
- query1_ready / query2_ready  out  1  tagged value is available
- query1_val / query2_val  out  32  tagged value
- rob_to_rf_ready  out  1  commit pulse
- rob_to_rf_reg_id  out  5  committed destination
- rob_to_rf_reg_val  out  32  committed value
- rob_to_rf_rob_index  out  ROB_WIDTH  committed tag
- clr_out  out  1  flush pulse (to RegFile clr_in and all stations)
- clr_pc  out  32  fetch redirect target, valid with clr_out

## Operation
- Circular buffer with head, tail and count.
- Tag increment wraps MAX→1 and skips 0.
- Per-entry fields: busy, ready, rd, val, is_branch, pred_taken, taken, redirect_pc.
- Allocate: if issue_valid && !rob_full && !clr_out:
  - write entry[tail] with busy=1, ready=0;
  - advance tail.
- rob_full = (count == 2^ROB_WIDTH-1), computed from registered count only. A same-cycle commit does not free a slot for a same-cycle allocation.
- CDB: if cdb_valid and entry[cdb_rob_index].busy:
  - set ready=1 and store val and taken;
  - a CDB hit on a non-busy entry is dropped.
- Commit: if entry[head].busy && ready:
  - register rob_to_rf_* ← {1, rd, val, head};
  - clear busy and advance head.
  - Otherwise rob_to_rf_ready ← 0.
- Mispredict: when the committing entry has is_branch && taken != pred_taken:
  - in the same cycle, register clr_out←1 and clr_pc←redirect_pc;
  - clear all busy bits, set head=tail=1 and count=0;
  - the commit pulse for that entry is still issued (a link register write is allowed).
- Query: ready = entry busy && ready, or a same-cycle cdb_valid match (bypass; the CDB value wins). Tag 0 returns ready=0 and val=0.
- Count: +1 on allocate, −1 on commit, unchanged when both occur; reset to 0 on flush.

## Timing
- Reset: head=tail=1, count=0, all busy=0.
  - All outputs 0, except rob_next_index=1.
- rob_next_index and rob_full are combinational from registers. An allocation at edge E uses the tag presented before E.
- Result on CDB at edge E → commit pulse visible after edge E+1 (one cycle minimum). At most one commit per cycle.
- rob_to_rf_ready and clr_out are single-cycle registered pulses while rdy_in is high.
- When rdy_in is low, all registers hold. Only the first rdy_in-high cycle is consumed downstream.
- Cycle with clr_out high: issue_valid and cdb_valid are ignored.
- Reset mid-operation discards all entries in one cycle.

## Structure
- Shared consts.v holds:
  - the ROB_NULL tag (0);
  - the tag-increment function (wrap MAX→1);
  - the ROB_WIDTH default.
- Single flat module; no sub-module is needed.

## Test plan
- Reset, then issue rd=5 ×3 → tags 1, 2, 3; rob_next_index=4.
- CDB tag 2 (val 0x22) then tag 1 (0x11) → commits in order: {5, 0x11, 1}, then {5, 0x22, 2}, back-to-back.
- Fill 15 entries → rob_full=1. Tag after 15 is 1. The 16th issue_valid is ignored. One commit → the next allocation succeeds with tag 1.
- Branch tag 3 with pred_taken=0, CDB taken=1, redirect_pc 0x100 → at its commit: clr_out=1, clr_pc=0x100; then rob_next_index=1 and rob_full=0.
- query1_index=4 with cdb_valid tag 4 val 0xAB in the same cycle → query1_ready=1, val 0xAB. query of tag 0 → ready=0.
- Hold rdy_in low for 3 cycles during a pending commit → outputs frozen. Exactly one commit is taken after rdy_in rises.
